// File: rtl/apb_ctrl_pkg.sv
// Shared APB master types: FSM state encoding and default bus widths.
package apb_ctrl_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first unmasked request searching upward from ptr with wrap.
// Latency: combinational. Backpressure: none; the caller holds ptr and decides when to accept.
// Masked requests are invisible for the cycle the mask is high.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     win_id,
  output logic               win_vld
);

  always_comb begin
    int idx;
    logic [IDW-1:0] sel;
    idx     = 0;
    sel     = '0;
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDW'(idx);
      if (!win_vld && req[sel] && !mask[sel]) begin
        win_vld = 1'b1;
        win_id  = sel;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB slave between NUM_REQ requesters with round-robin arbitration.
// Latency: request seen in IDLE at N -> SETUP N+1, ACCESS N+2, done pulse N+3.
// Backpressure: requesters hold i_req until done; APB_PREADY_EN adds slave wait states.
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]          o_req_done,
  output logic [DATA_W-1:0]           o_req_rdata,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic [ADDR_W-1:0]           o_paddr,
  output logic                        o_psel,
  output logic                        o_penable,
  output logic                        o_pwrite,
  output logic [DATA_W-1:0]           o_pwdata,
  input  logic [DATA_W-1:0]           i_prdata
`ifdef APB_PREADY_EN
  ,
  input  logic                        i_pready
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  apb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] win_id;
  logic           win_vld;
  logic           pready;
  logic           xfer_done;

`ifdef APB_PREADY_EN
  assign pready = i_pready;
`else
  assign pready = 1'b1;
`endif

  assign xfer_done = (state_q == ST_ACCESS) && pready;

  // The requester whose done pulse is out this cycle is masked so it cannot be regranted.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req     (i_req),
    .mask    (o_req_done),
    .ptr     (ptr_q),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  always_comb begin
    state_d   = state_q;
    o_psel    = 1'b0;
    o_penable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        o_psel  = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        if (pready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      o_grant_id  <= '0;
      o_paddr     <= '0;
      o_pwrite    <= 1'b0;
      o_pwdata    <= '0;
      o_req_done  <= '0;
      o_req_rdata <= '0;
    end else begin
      state_q    <= state_d;
      o_req_done <= '0;
      if (state_q == ST_IDLE && win_vld) begin
        o_grant_id <= win_id;
        o_pwrite   <= i_req_write[win_id];
        o_paddr    <= i_req_addr[int'(win_id)*ADDR_W +: ADDR_W];
        o_pwdata   <= i_req_wdata[int'(win_id)*DATA_W +: DATA_W];
      end
      if (xfer_done) begin
        if (!o_pwrite) o_req_rdata <= i_prdata;
        o_req_done <= NUM_REQ'(1) << o_grant_id;
        ptr_q      <= (o_grant_id == IDW'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: transaction-level reference model plus directed scenarios.
module tb_apb_rr_master;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic [0:0]      grant_id;
  logic [AW-1:0]   paddr;
  logic            psel, penable, pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;

  logic [DW-1:0]   slave_mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;
  int seen60  = 0;

  always #5 clk = ~clk;

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_done  (done),
    .o_req_rdata (rdata),
    .o_grant_id  (grant_id),
    .o_paddr     (paddr),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .o_pwdata    (pwdata),
    .i_prdata    (prdata)
`ifdef APB_PREADY_EN
    ,
    .i_pready    (pready)
`endif
  );

  // Zero-wait-state 256-word slave
  always_comb prdata = (psel && penable) ? slave_mem[paddr[7:0]] : '0;

  always @(posedge clk) begin
    if (psel && penable && pwrite && pready) slave_mem[paddr[7:0]] <= pwdata;
    if (psel && paddr == 32'h60) seen60++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which transfer is on the bus and what each requester has been told.
  int            m_phase = 0;  // 0 none, 1 first bus cycle, 2 data cycle
  int            m_ptr   = 0;
  int            m_grant = 0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [N-1:0]  m_done  = '0;
  logic [DW-1:0] m_mem [0:255];

  task automatic model_step();
    logic [N-1:0] nd;
    bit found;
    int k;
    nd = '0;
    found = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_grant = 0;
      m_write = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_phase == 0) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && req[k] && !m_done[k]) begin
          found   = 1'b1;
          m_grant = k;
          m_write = req_write[k];
          m_addr  = req_addr[k*AW +: AW];
          m_wdata = req_wdata[k*DW +: DW];
        end
      end
      if (found) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (pready) begin
      if (m_write) m_mem[m_addr[7:0]] = m_wdata;
      else         m_rdata = m_mem[m_addr[7:0]];
      nd[m_grant] = 1'b1;
      m_ptr   = (m_grant + 1) % N;
      m_phase = 0;
    end
    m_done = nd;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("psel",    psel,     m_phase != 0);
      chk("penable", penable,  m_phase == 2);
      chk("paddr",   paddr,    m_addr);
      chk("pwrite",  pwrite,   m_write);
      chk("pwdata",  pwdata,   m_wdata);
      chk("done",    done,     m_done);
      chk("rdata",   rdata,    m_rdata);
      chk("grant",   grant_id, m_grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k]                 = 1'b1;
    req_write[k]           = wr;
    req_addr[k*AW +: AW]   = a;
    req_wdata[k*DW +: DW]  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gid [4];
    int gcyc [4];
    int ndone;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = '0;
      m_mem[i]     = '0;
    end
    rst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0; pready = 1'b1;
    tick(); tick();
    chk("rst_psel", psel, 0);
    chk("rst_done", done, 0);
    chk("rst_paddr", paddr, 0);
    rst = 1'b0;

    // Single write then read back
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    tick(); chk("t1_setup_psel", psel, 1); chk("t1_setup_pen", penable, 0);
    tick(); chk("t1_access_pen", penable, 1); chk("t1_pwdata", pwdata, 32'hDEADBEEF);
    tick(); chk("t1_done", done, 2'b01);
    req[0] = 1'b0;
    tick();
    set_req(0, 1'b0, 32'h10, 32'h0);
    tick(); tick(); tick();
    chk("t1_rd_done", done, 2'b01);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    req[0] = 1'b0;

    // Both held: grants alternate every 3 cycles
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 1'b1, 32'h20, 32'h1111);
    set_req(1, 1'b1, 32'h21, 32'h2222);
    for (int i = 0; i < 4; i++) begin gid[i] = -1; gcyc[i] = -100; end
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      tick();
      if (done != '0) begin
        gid[ndone]  = done[1] ? 1 : 0;
        gcyc[ndone] = c;
        ndone++;
      end
    end
    req = '0;
    chk("t2_count", ndone, 4);
    chk("t2_grant0", gid[0], 0);
    chk("t2_grant1", gid[1], 1);
    chk("t2_grant2", gid[2], 0);
    chk("t2_grant3", gid[3], 1);
    for (int i = 1; i < 4; i++) chk("t2_gap", gcyc[i] - gcyc[i-1], 3);
    tick();

    // Request held through its done cycle: one idle cycle, then regrant
    set_req(0, 1'b0, 32'h20, 32'h0);
    tick(); tick(); tick();
    chk("t3_done", done, 2'b01);
    chk("t3_rdata", rdata, 32'h1111);
    tick(); chk("t3_no_regrant", psel, 0);
    tick(); chk("t3_regrant_psel", psel, 1); chk("t3_regrant_pen", penable, 0);
    set_req(0, 1'b0, 32'h21, 32'h0);
    tick(); chk("t3_addr_held", paddr, 32'h20);
    tick(); chk("t3_done2", done, 2'b01); chk("t3_rdata2", rdata, 32'h1111);
    req[0] = 1'b0;
    tick();

    // Reset during ACCESS drops the transfer and restores priority to req0
    set_req(0, 1'b0, 32'h30, 32'h0);
    tick(); tick(); chk("t4_access", penable, 1);
    rst = 1'b1;
    set_req(1, 1'b1, 32'h31, 32'h3333);
    tick();
    chk("t4_rst_psel", psel, 0); chk("t4_rst_pen", penable, 0);
    chk("t4_rst_done", done, 0); chk("t4_rst_paddr", paddr, 0);
    chk("t4_rst_grant", grant_id, 0);
    rst = 1'b0;
    tick(); chk("t4_grant", grant_id, 0); chk("t4_paddr", paddr, 32'h30); chk("t4_psel", psel, 1);
    tick(); tick(); chk("t4_done0", done, 2'b01);
    req[0] = 1'b0;
    tick(); tick(); tick(); chk("t4_done1", done, 2'b10);
    req[1] = 1'b0;
    tick();

    // Withdrawn request never reaches the bus
    set_req(0, 1'b1, 32'h50, 32'h5555);
    set_req(1, 1'b0, 32'h60, 32'h0);
    tick(); chk("t5_grant", grant_id, 0);
    req[1] = 1'b0;
    tick(); tick(); chk("t5_done", done, 2'b01);
    req[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_issue", seen60, 0);
    chk("t5_idle", psel, 0);

`ifdef APB_PREADY_EN
    // Wait states: three ACCESS cycles with pready low
    set_req(0, 1'b1, 32'h40, 32'hCAFEF00D);
    tick(); tick(); tick();
    req[0] = 1'b0;
    tick();
    set_req(0, 1'b0, 32'h40, 32'h0);
    tick();
    pready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_psel", psel, 1); chk("t6_pen", penable, 1);
      chk("t6_paddr", paddr, 32'h40); chk("t6_nodone", done, 0);
    end
    pready = 1'b1;
    tick();
    chk("t6_done", done, 2'b01);
    chk("t6_rdata", rdata, 32'hCAFEF00D);
    req[0] = 1'b0;
`endif

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Shares one APB slave port (the team's 256-word register/memory slave) between NUM_REQ local requesters.
- Round-robin arbitration picks one pending request, runs one APB transfer (SETUP then ACCESS), and returns a one-cycle done pulse plus read data to the winner.
- Sits between the TPU control/DMA requesters and the APB slave; it is the only master on that bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_req  in  NUM_REQ  per-requester request level
- i_req_write  in  NUM_REQ  1=write, 0=read, per requester
- i_req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester k at bits [k*ADDR_W +: ADDR_W]
- i_req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
- o_req_done  out  NUM_REQ  one-cycle completion pulse, one-hot
- o_req_rdata  out  DATA_W  read data, valid while o_req_done is high for a read
- o_grant_id  out  $clog2(NUM_REQ)  index of requester currently or last granted
- o_paddr  out  ADDR_W  APB address
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB direction
- o_pwdata  out  DATA_W  APB write data
- i_prdata  in  DATA_W  APB read data, combinational from slave during ACCESS
- i_pready  in  1  APB ready; present only when APB_PREADY_EN is defined

Behaviour:
- Reset (any cycle, including mid-transfer): state IDLE, RR pointer 0; every output 0. An interrupted transfer is dropped, with no done pulse.
- FSM: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE: if any eligible request is pending, choose the winner and latch its write/addr/wdata into o_pwrite/o_paddr/o_pwdata and its index into o_grant_id, then go to SETUP. Otherwise stay in IDLE.
- SETUP: o_psel=1, o_penable=0. Always go to ACCESS next cycle.
- ACCESS: o_psel=1, o_penable=1. The transfer completes this cycle (without the optional feature). On completion:
  - capture i_prdata into o_req_rdata if it is a read; on a write, o_req_rdata holds its previous value;
  - register o_req_done[grant]=1 for the following cycle;
  - set the RR pointer to grant+1 mod NUM_REQ;
  - go to IDLE.
- o_paddr, o_pwrite and o_pwdata stay stable from SETUP through ACCESS and hold their values in IDLE. Only o_psel and o_penable drop.
- Latency: request first seen in IDLE at cycle N gives SETUP at N+1, ACCESS at N+2, done at N+3. Minimum issue interval is 3 cycles.
- Round-robin: search from the pointer upward with wrap-around; first asserted eligible i_req wins. After reset requester 0 has top priority.
- Eligibility: in the cycle o_req_done[k] is high, requester k is masked from arbitration. This prevents a duplicate grant while the requester drops i_req.
- Handshake: requester holds i_req high until it sees done. Addr/data/write are sampled only at grant, so later changes are ignored.
  - i_req dropped before grant: the request is withdrawn and no transfer occurs.
  - i_req dropped after grant: the transfer completes and done still pulses.
- Requests arriving during SETUP or ACCESS wait for IDLE and are never lost while held.
- Simultaneous requests are resolved by the RR pointer only. The direction of the request does not affect priority.

Optional Feature:
- APB_PREADY_EN defined:
  - the i_pready port exists;
  - ACCESS repeats while i_pready=0, with all APB outputs held;
  - completion happens in the first ACCESS cycle with i_pready=1.
- APB_PREADY_EN undefined:
  - the port is absent;
  - ACCESS is always exactly one cycle, matching the zero-wait-state slave.

Decomposition:
- Shared package apb_ctrl_pkg:
  - state encoding ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2;
  - default APB_ADDR_W=32 and APB_DATA_W=32.
- Sub-module rr_arbiter:
  - NUM_REQ-wide request and mask inputs, pointer input;
  - outputs a winner index plus a valid flag;
  - purely combinational. The pointer register lives in apb_rr_master.

Test Plan:
- Reset then single write: req0 write addr 0x10 data 0xDEADBEEF.
  - Expect psel at N+1, penable at N+2, pwdata=0xDEADBEEF, done[0] at N+3.
  - A follow-up read of 0x10 returns o_req_rdata=0xDEADBEEF with done[0].
- Both requesters held, req0 write 0x20=0x1111 and req1 write 0x21=0x2222.
  - Grants alternate 0,1,0,1; each issue is 3 cycles apart.
  - No requester is granted twice in a row while the other is pending.
- Requester keeps i_req high during its done cycle, other requester idle.
  - No regrant in the done cycle; a new grant to the same requester starts the next cycle.
- Assert i_rst during ACCESS of a read to 0x30.
  - Next cycle all outputs are 0 and there is no done pulse.
  - Pointer is 0, so with both requesting, req0 wins first.
- Read request withdrawn one cycle into SETUP of another requester's transfer.
  - No transfer is ever issued for the withdrawn request.
- APB_PREADY_EN defined, i_pready low for 3 ACCESS cycles on read 0x40.
  - psel, penable and paddr are held for 4 ACCESS cycles; done is one cycle after i_pready=1, with the captured data.
